// File: rtl/ddr2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_pkg
// Description : Shared widths and arbiter state encoding for the DDR2 write
//               path.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr2_pkg;

  localparam int DDR2_ADDR_W = 31;
  localparam int DDR2_DATA_W = 128;
  localparam int DDR2_MASK_W = 16;

  // Burst phase of the write arbiter
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT1 = 2'd1,
    ST_BEAT2 = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr2
// Description : Two-requester grant selection. A 1-bit pointer names the
//               client favoured when both request at once.
//               Macro DDR2_ARB_FIXED_PRIORITY_EN: client 0 always wins and
//               the pointer input is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grant
);

`ifdef DDR2_ARB_FIXED_PRIORITY_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ptr;

  // Fixed priority: client 1 only when client 0 is silent
  always_comb begin
    grant = 1'b0;
    if (!req[0] && req[1]) grant = 1'b1;
  end
`else
  // Round robin: pointer breaks ties, a lone requester always wins
  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) grant = ptr;
    else if (req[1])  grant = 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/ddr2_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_write_arbiter
// Description : Merges two clients (0 = frame filler, 1 = line engine) onto
//               one DDR2 address / write-data FIFO pair, keeping each 2-beat
//               burst atomic. One bubble (IDLE) cycle per burst.
//               Macro DDR2_ARB_FIXED_PRIORITY_EN: client 0 always wins ties
//               and the round-robin pointer is omitted.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr2_write_arbiter
  import ddr2_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  // client 0
  input  logic [DDR2_ADDR_W-1:0] c0_af_addr_din,
  input  logic                   c0_af_wr_en,
  input  logic [DDR2_DATA_W-1:0] c0_wdf_din,
  input  logic [DDR2_MASK_W-1:0] c0_wdf_mask_din,
  input  logic                   c0_wdf_wr_en,
  output logic                   c0_af_full,
  output logic                   c0_wdf_full,
  // client 1
  input  logic [DDR2_ADDR_W-1:0] c1_af_addr_din,
  input  logic                   c1_af_wr_en,
  input  logic [DDR2_DATA_W-1:0] c1_wdf_din,
  input  logic [DDR2_MASK_W-1:0] c1_wdf_mask_din,
  input  logic                   c1_wdf_wr_en,
  output logic                   c1_af_full,
  output logic                   c1_wdf_full,
  // downstream FIFOs
  output logic [DDR2_ADDR_W-1:0] af_addr_din,
  output logic                   af_wr_en,
  input  logic                   af_full,
  output logic [DDR2_DATA_W-1:0] wdf_din,
  output logic [DDR2_MASK_W-1:0] wdf_mask_din,
  output logic                   wdf_wr_en,
  input  logic                   wdf_full
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  logic       r_grant;
  logic       w_ptr;
  logic       w_arb_grant;
  logic [1:0] w_req;

  // Granted client's view, muxed once for use everywhere below
  logic                   w_g_af_wr_en;
  logic                   w_g_wdf_wr_en;
  logic [DDR2_ADDR_W-1:0] w_g_addr;
  logic [DDR2_DATA_W-1:0] w_g_data;
  logic [DDR2_MASK_W-1:0] w_g_mask;
  logic                   w_beat1_go;
  logic                   w_beat2_go;

  assign w_req         = {c1_af_wr_en, c0_af_wr_en};
  assign w_g_af_wr_en  = r_grant ? c1_af_wr_en     : c0_af_wr_en;
  assign w_g_wdf_wr_en = r_grant ? c1_wdf_wr_en    : c0_wdf_wr_en;
  assign w_g_addr      = r_grant ? c1_af_addr_din  : c0_af_addr_din;
  assign w_g_data      = r_grant ? c1_wdf_din      : c0_wdf_din;
  assign w_g_mask      = r_grant ? c1_wdf_mask_din : c0_wdf_mask_din;

  // Beat 1 needs both FIFOs open and both strobes so the pair lands together
  assign w_beat1_go = w_g_af_wr_en & w_g_wdf_wr_en & ~af_full & ~wdf_full;
  assign w_beat2_go = w_g_wdf_wr_en & ~wdf_full;

  arb_rr2 u_arb (
    .req   (w_req),
    .ptr   (w_ptr),
    .grant (w_arb_grant)
  );

`ifdef DDR2_ARB_FIXED_PRIORITY_EN
  assign w_ptr = 1'b0;
`else
  logic r_ptr;
  assign w_ptr = r_ptr;

  // After each completed burst, favour the client that was not just served
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (r_state == ST_BEAT2 && w_beat2_go) begin
      r_ptr <= ~r_grant;
    end
  end
`endif

  // State and grant registers; grant is captured only when leaving IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && (|w_req)) r_grant <= w_arb_grant;
    end
  end

  // Next-state logic for the burst sequencer
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (|w_req)     w_state_next = ST_BEAT1;
      ST_BEAT1: if (w_beat1_go) w_state_next = ST_BEAT2;
      ST_BEAT2: if (w_beat2_go) w_state_next = ST_IDLE;
      default:                  w_state_next = ST_IDLE;
    endcase
  end

  // Downstream strobes/data and per-client backpressure
  always_comb begin
    af_wr_en     = 1'b0;
    wdf_wr_en    = 1'b0;
    af_addr_din  = '0;
    wdf_din      = '0;
    wdf_mask_din = '0;
    c0_af_full   = 1'b1;
    c0_wdf_full  = 1'b1;
    c1_af_full   = 1'b1;
    c1_wdf_full  = 1'b1;
    if (r_state == ST_BEAT1 || r_state == ST_BEAT2) begin
      af_addr_din  = w_g_addr;
      wdf_din      = w_g_data;
      wdf_mask_din = w_g_mask;
      if (r_grant) begin
        c1_af_full  = af_full;
        c1_wdf_full = wdf_full;
      end else begin
        c0_af_full  = af_full;
        c0_wdf_full = wdf_full;
      end
      if (r_state == ST_BEAT1) begin
        af_wr_en  = w_beat1_go;
        wdf_wr_en = w_beat1_go;
      end else begin
        wdf_wr_en = w_beat2_go;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr2_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr2_write_arbiter
// Description : Self-checking bench for ddr2_write_arbiter: directed bursts,
//               contention, backpressure, stalls, reset mid-burst, then
//               randomized traffic against a cycle-level burst model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr2_write_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [30:0]  c0_af_addr_din, c1_af_addr_din, af_addr_din;
  logic         c0_af_wr_en, c1_af_wr_en, af_wr_en;
  logic [127:0] c0_wdf_din, c1_wdf_din, wdf_din;
  logic [15:0]  c0_wdf_mask_din, c1_wdf_mask_din, wdf_mask_din;
  logic         c0_wdf_wr_en, c1_wdf_wr_en, wdf_wr_en;
  logic         c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full;
  logic         af_full, wdf_full;

  int checks   = 0;
  int failures = 0;

  // Model: phase 0 = waiting, 1 = first beat pending, 2 = second beat pending
  int m_phase = 0;
  int m_gnt   = 0;
  int m_fav   = 0;

  // Values seen at the last sample point
  logic        s_af_wr_en, s_wdf_wr_en, s_c0_af_full, s_c1_af_full, s_c1_wdf_full;
  logic [30:0] s_addr;
  logic [30:0] beat1_log[$];

  ddr2_write_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .c0_af_addr_din  (c0_af_addr_din),
    .c0_af_wr_en     (c0_af_wr_en),
    .c0_wdf_din      (c0_wdf_din),
    .c0_wdf_mask_din (c0_wdf_mask_din),
    .c0_wdf_wr_en    (c0_wdf_wr_en),
    .c0_af_full      (c0_af_full),
    .c0_wdf_full     (c0_wdf_full),
    .c1_af_addr_din  (c1_af_addr_din),
    .c1_af_wr_en     (c1_af_wr_en),
    .c1_wdf_din      (c1_wdf_din),
    .c1_wdf_mask_din (c1_wdf_mask_din),
    .c1_wdf_wr_en    (c1_wdf_wr_en),
    .c1_af_full      (c1_af_full),
    .c1_wdf_full     (c1_wdf_full),
    .af_addr_din     (af_addr_din),
    .af_wr_en        (af_wr_en),
    .af_full         (af_full),
    .wdf_din         (wdf_din),
    .wdf_mask_din    (wdf_mask_din),
    .wdf_wr_en       (wdf_wr_en),
    .wdf_full        (wdf_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_client(input int n, input logic af, input logic wdf,
                            input logic [30:0] addr, input logic [127:0] data,
                            input logic [15:0] mask);
    if (n == 0) begin
      c0_af_wr_en = af; c0_wdf_wr_en = wdf; c0_af_addr_din = addr;
      c0_wdf_din = data; c0_wdf_mask_din = mask;
    end else begin
      c1_af_wr_en = af; c1_wdf_wr_en = wdf; c1_af_addr_din = addr;
      c1_wdf_din = data; c1_wdf_mask_din = mask;
    end
  endtask

  // One clock: compare every output with the model at the falling edge,
  // advance the model, then return just after the rising edge.
  task automatic tick();
    logic         gaf, gwdf, e_af, e_wdf;
    logic [30:0]  e_addr;
    logic [127:0] e_data;
    logic [15:0]  e_mask;
    logic         e_c0a, e_c0w, e_c1a, e_c1w;
    @(negedge clk);
    gaf    = (m_gnt == 1) ? c1_af_wr_en  : c0_af_wr_en;
    gwdf   = (m_gnt == 1) ? c1_wdf_wr_en : c0_wdf_wr_en;
    e_af = 1'b0; e_wdf = 1'b0; e_addr = '0; e_data = '0; e_mask = '0;
    e_c0a = 1'b1; e_c0w = 1'b1; e_c1a = 1'b1; e_c1w = 1'b1;
    if (m_phase != 0) begin
      e_addr = (m_gnt == 1) ? c1_af_addr_din  : c0_af_addr_din;
      e_data = (m_gnt == 1) ? c1_wdf_din      : c0_wdf_din;
      e_mask = (m_gnt == 1) ? c1_wdf_mask_din : c0_wdf_mask_din;
      if (m_gnt == 1) begin e_c1a = af_full; e_c1w = wdf_full; end
      else            begin e_c0a = af_full; e_c0w = wdf_full; end
      if (m_phase == 1) begin
        e_af  = gaf && gwdf && !af_full && !wdf_full;
        e_wdf = e_af;
      end else begin
        e_wdf = gwdf && !wdf_full;
      end
    end
    chk("af_wr_en",     af_wr_en,     e_af);
    chk("wdf_wr_en",    wdf_wr_en,    e_wdf);
    chk("af_addr_din",  af_addr_din,  e_addr);
    chk("wdf_din",      wdf_din,      e_data);
    chk("wdf_mask_din", wdf_mask_din, e_mask);
    chk("c0_af_full",   c0_af_full,   e_c0a);
    chk("c0_wdf_full",  c0_wdf_full,  e_c0w);
    chk("c1_af_full",   c1_af_full,   e_c1a);
    chk("c1_wdf_full",  c1_wdf_full,  e_c1w);
    s_af_wr_en = af_wr_en; s_wdf_wr_en = wdf_wr_en; s_addr = af_addr_din;
    s_c0_af_full = c0_af_full; s_c1_af_full = c1_af_full; s_c1_wdf_full = c1_wdf_full;
    if (af_wr_en === 1'b1) beat1_log.push_back(af_addr_din);
    // advance the burst model
    if (rst) begin
      m_phase = 0; m_gnt = 0; m_fav = 0;
    end else if (m_phase == 0) begin
      if (c0_af_wr_en && c1_af_wr_en) begin
`ifdef DDR2_ARB_FIXED_PRIORITY_EN
        m_gnt = 0;
`else
        m_gnt = m_fav;
`endif
        m_phase = 1;
      end else if (c0_af_wr_en || c1_af_wr_en) begin
        m_gnt   = c1_af_wr_en ? 1 : 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (e_af) m_phase = 2;
    end else begin
      if (e_wdf) begin
        m_phase = 0;
        m_fav   = 1 - m_gnt;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [30:0] a0, a1;
    a0 = 31'h00104000;
    a1 = 31'h00208000;
    rst = 1'b1; af_full = 1'b0; wdf_full = 1'b0;
    set_client(0, 1'b0, 1'b0, '0, '0, '0);
    set_client(1, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk); #1;
    tick();
    chk("reset_af_wr_en", s_af_wr_en, 1'b0);
    chk("reset_c1_full",  s_c1_af_full, 1'b1);
    rst = 1'b0;

    // Single client burst from c0
    set_client(0, 1'b1, 1'b1, a0, {8{16'h00FF}}, 16'h0000);
    tick();
    chk("single_idle_bubble", s_af_wr_en, 1'b0);
    tick();
    chk("single_beat1_en",   s_af_wr_en, 1'b1);
    chk("single_beat1_addr", s_addr, a0);
    chk("single_beat1_c1",   s_c1_af_full, 1'b1);
    set_client(0, 1'b0, 1'b1, a0, {8{16'h00FF}}, 16'h0000);
    tick();
    chk("single_beat2_en",  s_wdf_wr_en, 1'b1);
    chk("single_beat2_af",  s_af_wr_en, 1'b0);
    chk("single_beat2_c1",  s_c1_wdf_full, 1'b1);
    set_client(0, 1'b0, 1'b0, '0, '0, '0);
    tick();

    // Contention straight out of reset
    rst = 1'b1; tick(); rst = 1'b0;
    beat1_log.delete();
    set_client(0, 1'b1, 1'b1, a0, 128'h0A, 16'h0001);
    set_client(1, 1'b1, 1'b1, a1, 128'h0B, 16'h0002);
    repeat (13) tick();
    chk("contention_count", (beat1_log.size() >= 4), 1'b1);
    for (int i = 0; i < 4 && i < beat1_log.size(); i++) begin
`ifdef DDR2_ARB_FIXED_PRIORITY_EN
      chk("contention_order", beat1_log[i], a0);
`else
      chk("contention_order", beat1_log[i], (i % 2 == 0) ? a0 : a1);
`endif
    end
    set_client(0, 1'b0, 1'b0, '0, '0, '0);
    set_client(1, 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1; tick(); rst = 1'b0;

    // Backpressure in beat 1, then a stall in beat 2
    set_client(0, 1'b1, 1'b1, a0, 128'h1234, 16'h00F0);
    tick();
    af_full = 1'b1;
    repeat (4) begin
      tick();
      chk("bp_af_held",  s_af_wr_en, 1'b0);
      chk("bp_wdf_held", s_wdf_wr_en, 1'b0);
    end
    af_full = 1'b0;
    tick();
    chk("bp_release", s_af_wr_en, 1'b1);
    set_client(0, 1'b0, 1'b1, a0, 128'h5678, 16'h00F0);
    wdf_full = 1'b1;
    repeat (3) begin
      tick();
      chk("stall_wdf_held", s_wdf_wr_en, 1'b0);
    end
    wdf_full = 1'b0;
    tick();
    chk("stall_release", s_wdf_wr_en, 1'b1);
    set_client(0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("stall_back_idle", s_c0_af_full, 1'b1);

    // Beat-1 protocol violation: wdf strobe alone
    set_client(0, 1'b1, 1'b1, a0, 128'h9, 16'h0);
    tick();
    set_client(0, 1'b0, 1'b1, a0, 128'h9, 16'h0);
    repeat (2) begin
      tick();
      chk("violation_no_write", s_wdf_wr_en, 1'b0);
    end
    set_client(0, 1'b1, 1'b1, a0, 128'h9, 16'h0);
    tick();
    chk("violation_still_beat1", s_af_wr_en, 1'b1);

    // Reset in beat 2 (pointer was moved to c1 by an earlier c0 burst)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_client(0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("rst_mid_idle_en", s_wdf_wr_en, 1'b0);
    chk("rst_mid_full",    s_c0_af_full, 1'b1);
    beat1_log.delete();
    set_client(0, 1'b1, 1'b1, a0, 128'h1, 16'h0);
    set_client(1, 1'b1, 1'b1, a1, 128'h2, 16'h0);
    repeat (3) tick();
    chk("rst_ptr_c0", (beat1_log.size() > 0) ? beat1_log[0] : 31'h7FFFFFFF, a0);

    // Randomized traffic
    repeat (400) begin
      rst      = ($urandom_range(0, 39) == 0);
      af_full  = ($urandom_range(0, 3) == 0);
      wdf_full = ($urandom_range(0, 3) == 0);
      set_client(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 31'($urandom), {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
      set_client(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 31'($urandom), {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
